// File: rtl/scr1_dmem_xbar2.sv
// Two-target DMEM crossbar: TCM window to port 0, everything else to port 1, one transaction in flight.
// Optional response watchdog with a DRAIN state is built when SCR1_DMEM_XBAR2_TIMEOUT_EN is defined.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_xbar2_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_xbar2
    import scr1_dmem_xbar2_pkg::*;
#(
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] PORT0_BASE     = 32'hF000_0000,
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] PORT0_MASK     = 32'hFFFF_0000,
    parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         core_req_i,
    output logic                         core_req_ack_o,
    input  type_scr1_mem_cmd_e           core_cmd_i,
    input  type_scr1_mem_width_e         core_width_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] core_addr_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] core_wdata_i,
    output logic [`SCR1_DMEM_DWIDTH-1:0] core_rdata_o,
    output type_scr1_mem_resp_e          core_resp_o,

    output logic                         port0_req_o,
    input  logic                         port0_req_ack_i,
    output type_scr1_mem_cmd_e           port0_cmd_o,
    output type_scr1_mem_width_e         port0_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0] port0_addr_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0] port0_wdata_o,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] port0_rdata_i,
    input  type_scr1_mem_resp_e          port0_resp_i,

    output logic                         port1_req_o,
    input  logic                         port1_req_ack_i,
    output type_scr1_mem_cmd_e           port1_cmd_o,
    output type_scr1_mem_width_e         port1_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0] port1_addr_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0] port1_wdata_o,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] port1_rdata_i,
    input  type_scr1_mem_resp_e          port1_resp_i
);

`ifdef SCR1_DMEM_XBAR2_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1
    } state_e;
`endif

    state_e                         state_reg;
    logic                           sel_reg;
    logic                           sel_new;
    logic                           req_window;
    logic                           handshake;
    logic                           resp_valid;
    logic                           timeout_hit;
    logic [1:0]                     port_ack;
    logic [1:0]                     port_req;
    type_scr1_mem_resp_e            port_resp  [2];
    logic [`SCR1_DMEM_DWIDTH-1:0]   port_rdata [2];
    type_scr1_mem_resp_e            act_resp;
    logic [`SCR1_DMEM_DWIDTH-1:0]   act_rdata;

    assign port_ack      = {port1_req_ack_i, port0_req_ack_i};
    assign port_resp[0]  = port0_resp_i;
    assign port_resp[1]  = port1_resp_i;
    assign port_rdata[0] = port0_rdata_i;
    assign port_rdata[1] = port1_rdata_i;

    assign sel_new    = ((core_addr_i & PORT0_MASK) != PORT0_BASE);
    assign act_resp   = port_resp[sel_reg];
    assign act_rdata  = port_rdata[sel_reg];
    assign resp_valid = (act_resp != SCR1_MEM_RESP_NOTRDY);

    // A new request may only be issued when no transaction is pending or the pending one completes now.
    always_comb begin
        req_window = 1'b0;
        case (state_reg)
            ST_IDLE: req_window = 1'b1;
            ST_RESP: req_window = resp_valid;
            default: req_window = 1'b0;
        endcase
    end

    assign core_req_ack_o = core_req_i & port_ack[sel_new] & req_window;
    assign handshake      = core_req_i & core_req_ack_o;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port_req
        assign port_req[gi] = core_req_i & (sel_new == 1'(gi)) & req_window;
    end

    assign port0_req_o   = port_req[0];
    assign port1_req_o   = port_req[1];
    assign port0_cmd_o   = core_cmd_i;
    assign port1_cmd_o   = core_cmd_i;
    assign port0_width_o = core_width_i;
    assign port1_width_o = core_width_i;
    assign port0_addr_o  = core_addr_i;
    assign port1_addr_o  = core_addr_i;
    assign port0_wdata_o = core_wdata_i;
    assign port1_wdata_o = core_wdata_i;

    always_comb begin
        core_resp_o  = SCR1_MEM_RESP_NOTRDY;
        core_rdata_o = '0;
        if (state_reg == ST_RESP) begin
            if (timeout_hit) begin
                core_resp_o = SCR1_MEM_RESP_RDY_ER;
            end else begin
                core_resp_o  = act_resp;
                core_rdata_o = act_rdata;
            end
        end
    end

`ifdef SCR1_DMEM_XBAR2_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt_reg;

    // A real response in the limit cycle wins over the synthetic error.
    assign timeout_hit = (state_reg == ST_RESP) & ~resp_valid & (tmo_cnt_reg == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
        end else if (handshake) begin
            tmo_cnt_reg <= '0;
        end else if ((state_reg == ST_RESP) && !resp_valid) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        sel_reg   <= sel_new;
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_valid) begin
                        if (handshake) begin
                            sel_reg <= sel_new;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
`ifdef SCR1_DMEM_XBAR2_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_reg <= ST_DRAIN;
                    end
`endif
                end
`ifdef SCR1_DMEM_XBAR2_TIMEOUT_EN
                // The abandoned response still has to arrive before the port can be reused.
                ST_DRAIN: begin
                    if (resp_valid) begin
                        state_reg <= ST_IDLE;
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
